aes_round_sequencer: RTL

//  Parametrised successor to the fixed-count AES round counter. Sequences one AES block
//  for AES-128/192/256 (Nr = 10/12/14), with start/done handshake, stall, abort and

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_round_counter_ld.sv | 28 ++
 rtl/aes_round_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES sequencing types: key lengths, round counts and sequencer states.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } key_len_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } seq_state_t;

endpackage

// File: rtl/aes_round_counter_ld.sv
// Round index counter: clear to zero, count on enable, flag the round before Nr.
module aes_round_counter_ld #(
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [CNT_SIZE-1:0] nr,
    output logic [CNT_SIZE-1:0] cnt,
    output logic                term
);

    localparam logic [CNT_SIZE-1:0] ONE = CNT_SIZE'(1);

    assign term = (cnt == (nr - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences one AES block (AES-128/192/256) with stall, abort and round flags.
module aes_round_sequencer #(
    parameter int CNT_SIZE = 4,
    parameter int NR_128   = aes_pkg::NR_128,
    parameter int NR_192   = aes_pkg::NR_192,
    parameter int NR_256   = aes_pkg::NR_256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_key_len,
    input  logic                i_stall,
    input  logic                i_abort,
    output logic                o_ready,
    output logic                o_busy,
    output logic [CNT_SIZE-1:0] o_round,
    output logic                o_first_round,
    output logic                o_last_round,
    output logic                o_key_exp_en,
    output logic                o_done,
    output logic                o_err
);

    import aes_pkg::*;

    if (CNT_SIZE < 4) begin : g_cnt_size_chk
        $error("CNT_SIZE must be at least 4");
    end

    seq_state_t          state;
    logic [CNT_SIZE-1:0] nr;
    logic                term;
    logic                cnt_clr;
    logic                cnt_en;

    function automatic logic [CNT_SIZE-1:0] nr_of(input logic [1:0] kl);
        case (key_len_t'(kl))
            KEY_192: nr_of = CNT_SIZE'(NR_192);
            KEY_256: nr_of = CNT_SIZE'(NR_256);
            default: nr_of = CNT_SIZE'(NR_128);
        endcase
    endfunction

    assign o_ready       = (state == IDLE);
    assign o_first_round = (state == INIT);
    assign o_last_round  = (state == FINAL);
    assign o_done        = (state == DONE);
    assign o_busy        = (state == INIT) || (state == ROUND) || (state == FINAL);
    assign o_key_exp_en  = o_busy & ~i_stall;

    // FINAL holds the counter at Nr; DONE and IDLE keep it cleared for the next block.
    assign cnt_clr = i_abort || (state == IDLE) || (state == DONE);
    assign cnt_en  = ~i_stall && ((state == INIT) || (state == ROUND));

    aes_round_counter_ld #(
        .CNT_SIZE(CNT_SIZE)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .nr   (nr),
        .cnt  (o_round),
        .term (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            nr    <= CNT_SIZE'(NR_128);
            o_err <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (i_abort && (state != IDLE)) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_start && !i_abort) begin
                            if (i_key_len == KEY_RSVD) begin
                                o_err <= 1'b1;
                            end else begin
                                nr    <= nr_of(i_key_len);
                                state <= INIT;
                            end
                        end
                    end
                    INIT: begin
                        if (!i_stall) state <= ROUND;
                    end
                    ROUND: begin
                        if (!i_stall && term) state <= FINAL;
                    end
                    FINAL: begin
                        if (!i_stall) state <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
